// File: rtl/addsub_arbiter_if.sv
// addsub_arbiter_if: request/operand/result bundle between two requesters and the shared add/sub unit
// Ports (signals): req0/req1, a0/b0/a1/b1, op0/op1 from requesters; gnt0/gnt1, busy, y, carry, ovf, zero, valid, owner back
interface addsub_arbiter_if #(parameter int N = 2);
    localparam int W = 2 ** N;
    logic         req0, req1, op0, op1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, busy, valid, owner, carry, ovf, zero;
    logic [W-1:0] y;
    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1,
        input  gnt0, gnt1, busy, valid, owner, carry, ovf, zero, y
    );
    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1,
        output gnt0, gnt1, busy, valid, owner, carry, ovf, zero, y
    );
endinterface

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin arbiter in front of one shared W-bit adder/subtractor (IDLE -> EXEC -> DONE)
// Ports: clk, reset (sync, active-high); bus (slave modport) carries requests, operands, grants, result and flags
module addsub_arbiter #(parameter int N = 2) (
    input logic clk,
    input logic reset,
    addsub_arbiter_if.slave bus
);
    localparam int W = 2 ** N;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t       state;
    logic         last_owner, idx, op_r, win;
    logic [W-1:0] a_r, b_r, bx;
    logic [W:0]   sum;
    // subtraction is A + ~B + 1, so carry out of the top bit means "no borrow"
    assign bx  = b_r ^ {W{op_r}};
    assign sum = {1'b0, a_r} + {1'b0, bx} + {{W{1'b0}}, op_r};
    // a lone requester wins; on a tie the one that did not win last time goes
    assign win = (bus.req0 && bus.req1) ? ~last_owner : bus.req1;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            idx        <= 1'b0;
            op_r       <= 1'b0;
            a_r        <= '0;
            b_r        <= '0;
            bus.gnt0   <= 1'b0;
            bus.gnt1   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.valid  <= 1'b0;
            bus.owner  <= 1'b0;
            bus.y      <= '0;
            bus.carry  <= 1'b0;
            bus.ovf    <= 1'b0;
            bus.zero   <= 1'b0;
        end else begin
            bus.gnt0  <= 1'b0;
            bus.gnt1  <= 1'b0;
            bus.valid <= 1'b0;
            case (state)
                IDLE: if (bus.req0 || bus.req1) begin
                    state      <= EXEC;
                    bus.busy   <= 1'b1;
                    last_owner <= win;
                    idx        <= win;
                    a_r        <= win ? bus.a1 : bus.a0;
                    b_r        <= win ? bus.b1 : bus.b0;
                    op_r       <= win ? bus.op1 : bus.op0;
                    bus.gnt0   <= ~win;
                    bus.gnt1   <= win;
                end
                EXEC: begin
                    state     <= DONE;
                    bus.y     <= sum[W-1:0];
                    bus.carry <= sum[W];
                    bus.zero  <= sum[W-1:0] == '0;
                    bus.ovf   <= (a_r[W-1] == bx[W-1]) && (sum[W-1] != a_r[W-1]);
                    bus.valid <= 1'b1;
                    bus.owner <= idx;
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed and randomized checks of addsub_arbiter against a transaction-level model
// Ports: none (top-level bench); drives clk/reset and the bus interface
module tb_addsub_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    addsub_arbiter_if #(.N(2)) bus ();
    addsub_arbiter #(.N(2)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    // reference: plain integer arithmetic, flags from unsigned/signed range rules
    function automatic logic [6:0] ref_calc(input logic [3:0] a, input logic [3:0] b, input logic op);
        int ua, ub, sa, sb, r, sr;
        logic c, v;
        logic [3:0] y;
        ua = a;
        ub = b;
        sa = (a >= 8) ? ua - 16 : ua;
        sb = (b >= 8) ? ub - 16 : ub;
        if (!op) begin
            r  = ua + ub;
            c  = r >= 16;
            sr = sa + sb;
        end else begin
            r  = ua - ub;
            c  = ua >= ub;
            sr = sa - sb;
        end
        y = 4'(r & 15);
        v = (sr > 7) || (sr < -8);
        return {c, v, y == 4'd0, y};
    endfunction

    task automatic quiet_inputs();
        bus.req0 = 0; bus.req1 = 0; bus.op0 = 0; bus.op1 = 0;
        bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        quiet_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.busy, bus.valid, bus.owner} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: gnt0 gnt1 busy valid owner=%b required 00000",
                     {bus.gnt0, bus.gnt1, bus.busy, bus.valid, bus.owner});
        end
        checks++;
        if ({bus.y, bus.carry, bus.ovf, bus.zero} !== 7'b0) begin
            failures++;
            $display("FAIL reset_result: y=%h c=%b v=%b z=%b required all 0", bus.y, bus.carry, bus.ovf, bus.zero);
        end
    endtask

    task automatic test_add();
        bus.req0 = 1; bus.a0 = 3; bus.b0 = 5; bus.op0 = 0;
        @(negedge clk);
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.busy, bus.valid} !== 4'b1010) begin
            failures++;
            $display("FAIL add_grant: gnt0 gnt1 busy valid=%b required 1010", {bus.gnt0, bus.gnt1, bus.busy, bus.valid});
        end
        bus.req0 = 0;
        @(negedge clk);
        checks++;
        if ({bus.valid, bus.owner, bus.y, bus.carry, bus.ovf, bus.zero, bus.gnt0} !== {1'b1, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL add_result: valid=%b owner=%b y=%h c=%b v=%b z=%b gnt0=%b required 1 0 8 0 1 0 0",
                     bus.valid, bus.owner, bus.y, bus.carry, bus.ovf, bus.zero, bus.gnt0);
        end
        @(negedge clk);
        checks++;
        if ({bus.valid, bus.busy, bus.y} !== {1'b0, 1'b0, 4'd8}) begin
            failures++;
            $display("FAIL add_after: valid=%b busy=%b y=%h required 0 0 8", bus.valid, bus.busy, bus.y);
        end
    endtask

    task automatic test_sub_zero();
        bus.req1 = 1; bus.a1 = 5; bus.b1 = 5; bus.op1 = 1;
        @(negedge clk);
        checks++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            failures++;
            $display("FAIL sub_grant: gnt0 gnt1=%b required 01", {bus.gnt0, bus.gnt1});
        end
        bus.req1 = 0;
        @(negedge clk);
        checks++;
        if ({bus.valid, bus.owner, bus.y, bus.carry, bus.ovf, bus.zero} !== {1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL sub_result: valid=%b owner=%b y=%h c=%b v=%b z=%b required 1 1 0 1 0 1",
                     bus.valid, bus.owner, bus.y, bus.carry, bus.ovf, bus.zero);
        end
        @(negedge clk);
    endtask

    task automatic test_operand_change();
        bus.req0 = 1; bus.a0 = 6; bus.b0 = 9; bus.op0 = 0;
        @(negedge clk);
        bus.req0 = 0; bus.a0 = 1; bus.b0 = 1; bus.op0 = 1;
        @(negedge clk);
        checks++;
        if ({bus.valid, bus.y, bus.carry, bus.ovf, bus.zero} !== {1'b1, 4'hF, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL operand_hold: valid=%b y=%h c=%b v=%b z=%b required 1 f 0 0 0",
                     bus.valid, bus.y, bus.carry, bus.ovf, bus.zero);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap_busy();
        int busy_cycles = 0;
        bus.req0 = 1; bus.a0 = 4'hF; bus.b0 = 1; bus.op0 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req0 = 0;
            if (bus.busy === 1'b1) busy_cycles++;
            if (i == 1) begin
                checks++;
                if ({bus.valid, bus.y, bus.carry, bus.ovf, bus.zero} !== {1'b1, 4'd0, 1'b1, 1'b0, 1'b1}) begin
                    failures++;
                    $display("FAIL wrap_result: valid=%b y=%h c=%b v=%b z=%b required 1 0 1 0 1",
                             bus.valid, bus.y, bus.carry, bus.ovf, bus.zero);
                end
            end
        end
        checks++;
        if (busy_cycles != 2) begin
            failures++;
            $display("FAIL wrap_busy_len: busy cycles=%0d required 2", busy_cycles);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        do_reset();
        bus.a0 = 2; bus.b0 = 7; bus.op0 = 1;
        bus.a1 = 4; bus.b1 = 3; bus.op1 = 0;
        bus.req0 = 1; bus.req1 = 1;
        for (int s = 0; s < 4; s++) begin
            exp_g = (s % 2 == 0) ? 2'b10 : 2'b01;
            @(negedge clk);
            checks++;
            if ({bus.gnt0, bus.gnt1} !== exp_g) begin
                failures++;
                $display("FAIL rr_grant%0d: gnt0 gnt1=%b required %b", s, {bus.gnt0, bus.gnt1}, exp_g);
            end
            @(negedge clk);
            if (s == 3) begin
                bus.req0 = 0; bus.req1 = 0;
            end
            checks++;
            if (s % 2 == 0) begin
                if ({bus.valid, bus.owner, bus.y, bus.carry, bus.ovf} !== {1'b1, 1'b0, 4'hB, 1'b0, 1'b0}) begin
                    failures++;
                    $display("FAIL rr_result%0d: valid=%b owner=%b y=%h c=%b v=%b required 1 0 b 0 0",
                             s, bus.valid, bus.owner, bus.y, bus.carry, bus.ovf);
                end
            end else if ({bus.valid, bus.owner, bus.y, bus.carry, bus.ovf} !== {1'b1, 1'b1, 4'd7, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL rr_result%0d: valid=%b owner=%b y=%h c=%b v=%b required 1 1 7 0 0",
                         s, bus.valid, bus.owner, bus.y, bus.carry, bus.ovf);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rr_idle: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_reset_midflight();
        bus.req0 = 1; bus.a0 = 1; bus.b0 = 1; bus.op0 = 0;
        @(negedge clk);
        bus.req0 = 0;
        reset = 1;
        @(negedge clk);
        reset = 0;
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.busy, bus.valid, bus.owner, bus.y, bus.carry, bus.ovf, bus.zero} !== 12'b0) begin
            failures++;
            $display("FAIL midreset_state: gnt0 gnt1 busy valid owner y c v z=%b required all 0",
                     {bus.gnt0, bus.gnt1, bus.busy, bus.valid, bus.owner, bus.y, bus.carry, bus.ovf, bus.zero});
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL midreset_quiet%0d: valid=%b busy=%b required 0 0", i, bus.valid, bus.busy);
            end
        end
        bus.req0 = 1; bus.req1 = 1;
        @(negedge clk);
        bus.req0 = 0; bus.req1 = 0;
        checks++;
        if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
            failures++;
            $display("FAIL midreset_tie: gnt0 gnt1=%b required 10", {bus.gnt0, bus.gnt1});
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic last = 1'b1;
        logic win;
        logic [3:0] hold_y = 4'd0;
        logic [3:0] ea, eb;
        logic eop;
        logic [6:0] exp;
        do_reset();
        for (int s = 0; s < 60; s++) begin
            bus.req0 = 1'($urandom_range(0, 1));
            bus.req1 = 1'($urandom_range(0, 1));
            bus.a0 = 4'($urandom); bus.b0 = 4'($urandom); bus.op0 = 1'($urandom);
            bus.a1 = 4'($urandom); bus.b1 = 4'($urandom); bus.op1 = 1'($urandom);
            @(negedge clk);
            if (!bus.req0 && !bus.req1) begin
                checks++;
                if ({bus.gnt0, bus.gnt1, bus.busy, bus.valid, bus.y} !== {4'b0, hold_y}) begin
                    failures++;
                    $display("FAIL rand_idle%0d: gnt0 gnt1 busy valid=%b y=%h required 0000 %h",
                             s, {bus.gnt0, bus.gnt1, bus.busy, bus.valid}, bus.y, hold_y);
                end
                continue;
            end
            win = (bus.req0 && bus.req1) ? !last : bus.req1;
            last = win;
            ea = win ? bus.a1 : bus.a0;
            eb = win ? bus.b1 : bus.b0;
            eop = win ? bus.op1 : bus.op0;
            exp = ref_calc(ea, eb, eop);
            checks++;
            if ({bus.gnt0, bus.gnt1} !== {!win, win}) begin
                failures++;
                $display("FAIL rand_grant%0d: gnt0 gnt1=%b required %b", s, {bus.gnt0, bus.gnt1}, {!win, win});
            end
            bus.req0 = 0; bus.req1 = 0;
            bus.a0 = 4'($urandom); bus.b0 = 4'($urandom); bus.op0 = 1'($urandom);
            bus.a1 = 4'($urandom); bus.b1 = 4'($urandom); bus.op1 = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({bus.valid, bus.owner, bus.carry, bus.ovf, bus.zero, bus.y} !== {1'b1, win, exp}) begin
                failures++;
                $display("FAIL rand_result%0d: valid=%b owner=%b c v z y=%b required 1 %b %b (a=%h b=%h op=%b)",
                         s, bus.valid, bus.owner, {bus.carry, bus.ovf, bus.zero, bus.y}, win, exp, ea, eb, eop);
            end
            hold_y = exp[3:0];
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1;
        quiet_inputs();
        test_reset();
        test_add();
        test_sub_zero();
        test_operand_change();
        test_wrap_busy();
        test_round_robin();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter: N, default 2, operand width W = 2**N bits.
REQ-002 clk  input  1  rising-edge system clock; all state updates on this edge only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 req0, req1  input  1 each  requester 0/1 operation request, level, held until matching grant.
REQ-005 a0, b0, a1, b1  input  W each  requester operands, held stable while corresponding req is high.
REQ-006 op0, op1  input  1 each  operation select: 0 = A+B, 1 = A-B.
REQ-007 gnt0, gnt1  output  1 each  one-cycle grant pulse: operands of that requester captured.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 y  output  W  registered result.
REQ-010 carry, ovf, zero  output  1 each  registered flags for y.
REQ-011 valid  output  1  one-cycle pulse: y and flags are new.
REQ-012 owner  output  1  requester index of the result qualified by valid.

Function
REQ-013 FSM states IDLE, EXEC, DONE; IDLE->EXEC when req0|req1 sampled high; EXEC->DONE unconditionally; DONE->IDLE unconditionally.
REQ-014 In IDLE with no request, state, operand registers and outputs other than pulses shall hold.
REQ-015 IDLE with exactly one req high: that requester wins.
REQ-016 IDLE with both req high: winner is the requester not equal to last_owner (round robin).
REQ-017 last_owner register updated to winner on IDLE->EXEC transition.
REQ-018 On IDLE->EXEC, winner's a, b, op and index latched into internal registers; gnt of winner high for the whole EXEC cycle, other gnt low.
REQ-019 Single shared adder: sum = a + (b XOR {W{op}}) + op, computed from latched operands, W+1 bits wide.
REQ-020 On EXEC->DONE: y = sum[W-1:0]; carry = sum[W]; zero = (y == 0); ovf = (a[W-1] == bx[W-1]) AND (y[W-1] != a[W-1]), bx = b XOR {W{op}}.
REQ-021 For subtraction carry = 1 means no borrow (A >= B unsigned).
REQ-022 valid high and owner = latched index for the whole DONE cycle; y, flags, owner hold afterwards until the next DONE.
REQ-023 Latency: req sampled at edge k -> gnt high cycle k..k+1 -> valid high cycle k+1..k+2 -> IDLE at edge k+3; max one operation per 3 cycles.
REQ-024 Requester shall drop req by the edge after its gnt; req still high in IDLE is a new request.
REQ-025 Loser's req is ignored during EXEC/DONE and re-arbitrated in next IDLE; no request lost while held.
REQ-026 Operand changes on a0..b1/op during EXEC or DONE shall not affect the in-flight result.

Reset
REQ-027 On reset: state IDLE, last_owner = 1 (req0 wins first tie), gnt0 = gnt1 = 0, busy = 0, valid = 0, owner = 0, y = 0, carry = 0, ovf = 0, zero = 0, operand registers 0.
REQ-028 Reset overrides every state incl. EXEC/DONE; in-flight operation discarded, no valid pulse issued for it.

Verification
REQ-029 W=4, req0 alone, a0=3, b0=5, op0=0 -> gnt0 next cycle, then valid, owner=0, y=8, carry=0, ovf=1, zero=0.
REQ-030 req1 alone, a1=5, b1=5, op1=1 -> valid, owner=1, y=0, carry=1, zero=1, ovf=0.
REQ-031 After reset, req0 and req1 both held: grants gnt0, gnt1, gnt0, gnt1 in successive 3-cycle slots; with a0=2,b0=7,op0=1 -> y=0xB, carry=0, ovf=0.
REQ-032 req0 only, a0=0xF, b0=1, op0=0 -> y=0, carry=1, zero=1, ovf=0; busy high exactly 2 cycles.
REQ-033 Reset asserted during EXEC -> next cycle state IDLE, no valid pulse, all outputs at reset values; next tie grants req0.
REQ-034 Change a0/b0 in the gnt0 cycle -> result uses values latched at grant edge.
